// File: rtl/common_register_bank.sv
// Parametrised register bank: NUM_DR data registers with shadow context bank,
// CR with W1C sticky status half, and a wrapping pointer register.
module common_register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DR     = 4,
  parameter int SEL_WIDTH  = 4,
  parameter int PTR_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [SEL_WIDTH-1:0]    wr_sel,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [SEL_WIDTH-1:0]    rd_sel_a,
  input  logic [SEL_WIDTH-1:0]    rd_sel_b,
  output logic [DATA_WIDTH-1:0]   rd_data_a,
  output logic [DATA_WIDTH-1:0]   rd_data_b,
  input  logic [DATA_WIDTH/2-1:0] flag_set,
  input  logic                    ptr_inc,
  input  logic                    ptr_dec,
  input  logic                    ctx_save,
  input  logic                    ctx_restore,
  output logic [DATA_WIDTH-1:0]   dr0,
  output logic [DATA_WIDTH-1:0]   dr1,
  output logic [DATA_WIDTH-1:0]   cr,
  output logic [DATA_WIDTH-1:0]   ptr,
  output logic                    ptr_wrap
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [SEL_WIDTH-1:0]  CR_SEL  = SEL_WIDTH'(NUM_DR);
  localparam logic [SEL_WIDTH-1:0]  PR_SEL  = SEL_WIDTH'(NUM_DR + 1);
  localparam logic [DATA_WIDTH:0]   DEPTH   = (DATA_WIDTH + 1)'(PTR_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PTR_MAX = DATA_WIDTH'(PTR_DEPTH - 1);

  logic [DATA_WIDTH-1:0] dr_q     [NUM_DR];
  logic [DATA_WIDTH-1:0] shadow_q [NUM_DR];
  logic [DATA_WIDTH-1:0] cr_q;
  logic [DATA_WIDTH-1:0] ptr_q;
  logic                  wrap_q;

  logic                  wr_cr;
  logic                  wr_pr;
  logic [HALF-1:0]       ctrl_next;
  logic [HALF-1:0]       status_next;
  logic [DATA_WIDTH-1:0] ptr_next;
  logic                  wrap_next;

  assign wr_cr = wr_en && (wr_sel == CR_SEL);
  assign wr_pr = wr_en && (wr_sel == PR_SEL);

  // Only DR targets are bypassed; CR/PR always return the registered value.
  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [SEL_WIDTH-1:0] sel);
    read_reg = '0;
    for (int unsigned i = 0; i < NUM_DR; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        read_reg = (wr_en && (wr_sel == sel)) ? wr_data : dr_q[i];
      end
    end
    if (sel == CR_SEL) read_reg = cr_q;
    if (sel == PR_SEL) read_reg = ptr_q;
  endfunction

  always_comb begin
    rd_data_a = read_reg(rd_sel_a);
    rd_data_b = read_reg(rd_sel_b);
  end

  // flag_set is OR'd after the W1C mask so a same-cycle set wins.
  always_comb begin
    ctrl_next   = cr_q[HALF-1:0];
    status_next = cr_q[DATA_WIDTH-1:HALF];
    if (wr_cr) begin
      ctrl_next   = wr_data[HALF-1:0];
      status_next = status_next & ~wr_data[DATA_WIDTH-1:HALF];
    end
    status_next = status_next | flag_set;
  end

  always_comb begin
    ptr_next  = ptr_q;
    wrap_next = 1'b0;
    if (wr_pr) begin
      ptr_next = DATA_WIDTH'({1'b0, wr_data} % DEPTH);
    end else if (ptr_inc && !ptr_dec) begin
      if (ptr_q == PTR_MAX) begin
        ptr_next  = '0;
        wrap_next = 1'b1;
      end else begin
        ptr_next = ptr_q + DATA_WIDTH'(1);
      end
    end else if (ptr_dec && !ptr_inc) begin
      if (ptr_q == '0) begin
        ptr_next  = PTR_MAX;
        wrap_next = 1'b1;
      end else begin
        ptr_next = ptr_q - DATA_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DR; i++) begin
        dr_q[i]     <= '0;
        shadow_q[i] <= '0;
      end
      cr_q   <= '0;
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      // Shadow samples pre-edge DRs, so save+restore together swaps the banks.
      for (int unsigned i = 0; i < NUM_DR; i++) begin
        if (wr_en && (wr_sel == SEL_WIDTH'(i))) begin
          dr_q[i] <= wr_data;
        end else if (ctx_restore) begin
          dr_q[i] <= shadow_q[i];
        end
        if (ctx_save) begin
          shadow_q[i] <= dr_q[i];
        end
      end
      cr_q   <= {status_next, ctrl_next};
      ptr_q  <= ptr_next;
      wrap_q <= wrap_next;
    end
  end

  assign dr0      = dr_q[0];
  assign dr1      = dr_q[1];
  assign cr       = cr_q;
  assign ptr      = ptr_q;
  assign ptr_wrap = wrap_q;

endmodule

// File: tb/tb_common_register_bank.sv
// Bench for common_register_bank: directed vector table, async-reset sequence,
// randomized run against a behavioural model, and a wide/large-bank instance.
module tb_common_register_bank;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, ptr_inc, ptr_dec, ctx_save, ctx_restore;
  logic [3:0] wr_sel, rd_sel_a, rd_sel_b, flag_set;
  logic [7:0] wr_data, rd_data_a, rd_data_b, dr0, dr1, cr, ptr;
  logic       ptr_wrap;

  logic        p_wr_en, p_inc, p_dec, p_save, p_restore, p_wrap;
  logic [3:0]  p_wr_sel, p_rd_a, p_rd_b;
  logic [7:0]  p_flag;
  logic [15:0] p_wr_data, p_data_a, p_data_b, p_dr0, p_dr1, p_cr, p_ptr;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  common_register_bank #(.DATA_WIDTH(8), .NUM_DR(4), .SEL_WIDTH(4), .PTR_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .flag_set(flag_set), .ptr_inc(ptr_inc), .ptr_dec(ptr_dec), .ctx_save(ctx_save),
    .ctx_restore(ctx_restore), .dr0(dr0), .dr1(dr1), .cr(cr), .ptr(ptr), .ptr_wrap(ptr_wrap)
  );

  common_register_bank #(.DATA_WIDTH(16), .NUM_DR(8), .SEL_WIDTH(4), .PTR_DEPTH(1000)) dut_wide (
    .clk(clk), .rst(rst), .wr_en(p_wr_en), .wr_sel(p_wr_sel), .wr_data(p_wr_data),
    .rd_sel_a(p_rd_a), .rd_sel_b(p_rd_b), .rd_data_a(p_data_a), .rd_data_b(p_data_b),
    .flag_set(p_flag), .ptr_inc(p_inc), .ptr_dec(p_dec), .ctx_save(p_save),
    .ctx_restore(p_restore), .dr0(p_dr0), .dr1(p_dr1), .cr(p_cr), .ptr(p_ptr), .ptr_wrap(p_wrap)
  );

  typedef struct {
    logic       we;
    logic [3:0] sel;
    logic [7:0] data;
    logic [3:0] ra, rb, flag;
    logic       inc, dec, sv, rs;
    logic [7:0] ea, eb, edr0, edr1, ecr, eptr;
    logic       ewrap;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic we, input logic [3:0] sel, input logic [7:0] data,
                             input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] flag,
                             input logic inc, input logic dec, input logic sv, input logic rs,
                             input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] edr0,
                             input logic [7:0] edr1, input logic [7:0] ecr, input logic [7:0] eptr,
                             input logic ewrap);
    vec_t t;
    t = '{we, sel, data, ra, rb, flag, inc, dec, sv, rs, ea, eb, edr0, edr1, ecr, eptr, ewrap};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model of the default-parameter instance.
  logic [7:0]  m_dr[4];
  logic [7:0]  m_sh[4];
  logic [7:0]  m_cr;
  int unsigned m_pr;
  bit          m_wrap;

  function automatic logic [7:0] m_read(input logic [3:0] sel);
    if (sel < 4) return (wr_en && wr_sel == sel) ? wr_data : m_dr[sel];
    if (sel == 4) return m_cr;
    if (sel == 5) return 8'(m_pr);
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin m_dr[i] = 8'h00; m_sh[i] = 8'h00; end
    m_cr = 8'h00; m_pr = 0; m_wrap = 1'b0;
  endtask

  task automatic m_step();
    logic [7:0] nd[4];
    logic [3:0] st;
    for (int i = 0; i < 4; i++)
      nd[i] = (wr_en && wr_sel == i) ? wr_data : (ctx_restore ? m_sh[i] : m_dr[i]);
    if (ctx_save) m_sh = m_dr;
    m_dr = nd;
    st = m_cr[7:4];
    if (wr_en && wr_sel == 4) begin
      st = st & ~wr_data[7:4];
      m_cr[3:0] = wr_data[3:0];
    end
    m_cr[7:4] = st | flag_set;
    m_wrap = 1'b0;
    if (wr_en && wr_sel == 5) m_pr = wr_data % D;
    else if (ptr_inc && !ptr_dec) begin m_wrap = (m_pr == D - 1); m_pr = (m_pr + 1) % D; end
    else if (ptr_dec && !ptr_inc) begin m_wrap = (m_pr == 0); m_pr = (m_pr + D - 1) % D; end
  endtask

  task automatic idle();
    wr_en = 0; wr_sel = 0; wr_data = 0; rd_sel_a = 0; rd_sel_b = 0; flag_set = 0;
    ptr_inc = 0; ptr_dec = 0; ctx_save = 0; ctx_restore = 0;
  endtask

  task automatic apply(input int idx, input vec_t t);
    wr_en = t.we; wr_sel = t.sel; wr_data = t.data; rd_sel_a = t.ra; rd_sel_b = t.rb;
    flag_set = t.flag; ptr_inc = t.inc; ptr_dec = t.dec; ctx_save = t.sv; ctx_restore = t.rs;
    #1;
    chk($sformatf("v%0d_rd_a", idx), rd_data_a, t.ea);
    chk($sformatf("v%0d_rd_b", idx), rd_data_b, t.eb);
    @(posedge clk); #1;
    chk($sformatf("v%0d_dr0", idx), dr0, t.edr0);
    chk($sformatf("v%0d_dr1", idx), dr1, t.edr1);
    chk($sformatf("v%0d_cr", idx), cr, t.ecr);
    chk($sformatf("v%0d_ptr", idx), ptr, t.eptr);
    chk($sformatf("v%0d_wrap", idx), ptr_wrap, t.ewrap);
  endtask

  task automatic p_apply(input string name, input logic we, input logic [3:0] sel,
                         input logic [15:0] data, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [7:0] flag, input logic dec, input logic [15:0] ea,
                         input logic [15:0] eb, input logic [15:0] ecr, input logic [15:0] eptr,
                         input logic ewrap);
    p_wr_en = we; p_wr_sel = sel; p_wr_data = data; p_rd_a = ra; p_rd_b = rb;
    p_flag = flag; p_dec = dec;
    #1;
    chk({name, "_rd_a"}, p_data_a, ea);
    chk({name, "_rd_b"}, p_data_b, eb);
    @(posedge clk); #1;
    chk({name, "_cr"}, p_cr, ecr);
    chk({name, "_ptr"}, p_ptr, eptr);
    chk({name, "_wrap"}, p_wrap, ewrap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    p_wr_en = 0; p_wr_sel = 0; p_wr_data = 0; p_rd_a = 0; p_rd_b = 0; p_flag = 0;
    p_inc = 0; p_dec = 0; p_save = 0; p_restore = 0;
    #3;
    chk("rst_dr0", dr0, 0); chk("rst_dr1", dr1, 0); chk("rst_cr", cr, 0);
    chk("rst_ptr", ptr, 0); chk("rst_wrap", ptr_wrap, 0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    //       we sel data ra rb flg inc dec sv rs  ea    eb    dr0   dr1   cr    ptr  wrap
    vt.push_back(v(1, 2, 8'h5A, 2, 6, 0, 0, 0, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    vt.push_back(v(0, 0, 8'h00, 2, 6, 0, 0, 0, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    vt.push_back(v(1, 4, 8'h03, 4, 6, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 0));
    vt.push_back(v(0, 0, 8'h00, 4, 6, 5, 0, 0, 0, 0, 8'h03, 8'h00, 8'h00, 8'h00, 8'h53, 8'h00, 0));
    vt.push_back(v(1, 4, 8'h13, 4, 6, 1, 0, 0, 0, 0, 8'h53, 8'h00, 8'h00, 8'h00, 8'h53, 8'h00, 0));
    vt.push_back(v(1, 4, 8'h43, 4, 6, 0, 0, 0, 0, 0, 8'h53, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 0));
    vt.push_back(v(1, 5, 8'h0F, 5, 4, 0, 0, 0, 0, 0, 8'h00, 8'h13, 8'h00, 8'h00, 8'h13, 8'h0F, 0));
    vt.push_back(v(0, 0, 8'h00, 5, 6, 0, 1, 0, 0, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 1));
    vt.push_back(v(0, 0, 8'h00, 5, 6, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 0));
    vt.push_back(v(0, 0, 8'h00, 5, 6, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0F, 1));
    vt.push_back(v(0, 0, 8'h00, 5, 6, 0, 1, 1, 0, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 5, 8'h23, 5, 6, 0, 0, 0, 0, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h03, 0));
    vt.push_back(v(1, 5, 8'h0F, 5, 6, 0, 1, 0, 0, 0, 8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 5, 8'h1F, 5, 6, 0, 1, 0, 0, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 0, 8'h01, 0, 6, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 1, 8'h02, 1, 0, 0, 0, 0, 0, 0, 8'h02, 8'h01, 8'h01, 8'h02, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 2, 8'h03, 2, 6, 0, 0, 0, 0, 0, 8'h03, 8'h00, 8'h01, 8'h02, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 3, 8'h04, 3, 2, 0, 0, 0, 0, 0, 8'h04, 8'h03, 8'h01, 8'h02, 8'h13, 8'h0F, 0));
    vt.push_back(v(0, 0, 8'h00, 0, 6, 0, 0, 0, 1, 0, 8'h01, 8'h00, 8'h01, 8'h02, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 0, 8'h0F, 0, 6, 0, 0, 0, 0, 0, 8'h0F, 8'h00, 8'h0F, 8'h02, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 1, 8'h0F, 1, 0, 0, 0, 0, 0, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 2, 8'h0F, 2, 6, 0, 0, 0, 0, 0, 8'h0F, 8'h00, 8'h0F, 8'h0F, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 3, 8'h0F, 3, 6, 0, 0, 0, 0, 0, 8'h0F, 8'h00, 8'h0F, 8'h0F, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 1, 8'h77, 1, 2, 0, 0, 0, 0, 1, 8'h77, 8'h0F, 8'h01, 8'h77, 8'h13, 8'h0F, 0));
    vt.push_back(v(0, 0, 8'h00, 2, 3, 0, 0, 0, 0, 0, 8'h03, 8'h04, 8'h01, 8'h77, 8'h13, 8'h0F, 0));
    vt.push_back(v(0, 0, 8'h00, 1, 6, 0, 0, 0, 1, 1, 8'h77, 8'h00, 8'h01, 8'h02, 8'h13, 8'h0F, 0));
    vt.push_back(v(0, 0, 8'h00, 1, 6, 0, 0, 0, 0, 1, 8'h02, 8'h00, 8'h01, 8'h77, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 0, 8'hAA, 0, 1, 0, 0, 0, 1, 0, 8'hAA, 8'h77, 8'hAA, 8'h77, 8'h13, 8'h0F, 0));
    vt.push_back(v(0, 0, 8'h00, 0, 6, 0, 0, 0, 0, 1, 8'hAA, 8'h00, 8'h01, 8'h77, 8'h13, 8'h0F, 0));
    vt.push_back(v(1, 7, 8'hFF, 7, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 8'h01, 8'h77, 8'h13, 8'h0F, 0));
    foreach (vt[i]) apply(i, vt[i]);

    // Async reset landing mid-cycle while a wrap pulse is high and strobes are live.
    idle();
    ptr_inc = 1; wr_en = 1; wr_sel = 0; wr_data = 8'h55;
    @(posedge clk); #1;
    chk("arst_pre_wrap", ptr_wrap, 1);
    chk("arst_pre_dr0", dr0, 8'h55);
    #3 rst = 1'b1;
    #1;
    chk("arst_dr0", dr0, 0); chk("arst_dr1", dr1, 0); chk("arst_cr", cr, 0);
    chk("arst_ptr", ptr, 0); chk("arst_wrap", ptr_wrap, 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_rel_wrap", ptr_wrap, 0); chk("arst_rel_ptr", ptr, 0);
    chk("arst_rel_dr0", dr0, 0); chk("arst_rel_cr", cr, 0);

    m_reset();
    for (int n = 0; n < 300; n++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_sel = 4'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      rd_sel_a = ($urandom_range(0, 1) == 0) ? wr_sel : 4'($urandom_range(0, 15));
      rd_sel_b = 4'($urandom_range(0, 15));
      flag_set = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ptr_inc = 1'($urandom_range(0, 1));
      ptr_dec = ($urandom_range(0, 3) == 0);
      ctx_save = ($urandom_range(0, 7) == 0);
      ctx_restore = ($urandom_range(0, 7) == 0);
      #1;
      chk("rnd_rd_a", rd_data_a, m_read(rd_sel_a));
      chk("rnd_rd_b", rd_data_b, m_read(rd_sel_b));
      @(posedge clk);
      m_step();
      #1;
      chk("rnd_dr0", dr0, m_dr[0]); chk("rnd_dr1", dr1, m_dr[1]);
      chk("rnd_cr", cr, m_cr); chk("rnd_ptr", ptr, 8'(m_pr)); chk("rnd_wrap", ptr_wrap, m_wrap);
    end
    idle();

    // Wide instance: CR at select 8, PR at 9, modulus 1000, status in [15:8].
    p_apply("w_flag",  0, 0, 16'h0000, 8, 10, 8'hFF, 0, 16'h0000, 16'h0000, 16'hFF00, 16'd0, 0);
    p_apply("w_w1c",   1, 8, 16'h0F34, 8, 10, 8'h00, 0, 16'hFF00, 16'h0000, 16'hF034, 16'd0, 0);
    p_apply("w_prmod", 1, 9, 16'h1234, 8, 9,  8'h00, 0, 16'hF034, 16'd0,    16'hF034, 16'd660, 0);
    p_apply("w_dr7",   1, 7, 16'hBEEF, 7, 9,  8'h00, 0, 16'hBEEF, 16'd660,  16'hF034, 16'd660, 0);
    p_apply("w_dec",   0, 0, 16'h0000, 7, 10, 8'h00, 1, 16'hBEEF, 16'h0000, 16'hF034, 16'd659, 0);
    p_apply("w_pr0",   1, 9, 16'd1000, 9, 8,  8'h00, 0, 16'd659,  16'hF034, 16'hF034, 16'd0, 0);
    p_apply("w_wrap",  0, 0, 16'h0000, 9, 10, 8'h00, 1, 16'd0,    16'h0000, 16'hF034, 16'd999, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
